alu_op_sequencer: RTL and testbench

//   Sequential front end that drives the combinational ALU datapath (a, b, op -> res).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: opcode and FSM state
// encodings plus a helper that decides whether an opcode is supported.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100
  } alu_op_e;

  typedef enum logic [2:0] {
    S_LD_A  = 3'd0,
    S_LD_B  = 3'd1,
    S_LD_OP = 3'd2,
    S_EXEC  = 3'd3,
    S_OUT   = 3'd4
  } seq_state_e;

  // Opcode value presented to the ALU after reset (decodes as invalid).
  localparam logic [2:0] OP_RESET = 3'b000;

  // Only the four defined opcodes are serviced by the ALU; all others
  // yield a zero result and must be flagged as errors.
  function automatic logic is_valid_op(input alu_op_e op);
    case (op)
      OP_ADD, OP_AND, OP_OR, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Input word stream and result stream between a producer/consumer (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int W = 8
);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_res;
  logic         out_cy;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_res,
    input  out_cy,
    input  out_err,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_res,
    output out_cy,
    output out_err,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Sequential front end for an external combinational ALU. Operand A,
// operand B and the opcode arrive one word at a time; the sequencer holds
// them steady on the ALU inputs, captures the result with carry/borrow and
// error flags, and hands it out over a valid/ready stream.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_res,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;

  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [2:0]       r_alu_op;
  logic [W-1:0]     r_out_res;
  logic             r_out_cy;
  logic             r_out_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_ld_op;
  logic             w_exec;
  logic             w_cnt_inc;
  logic             w_cy;
  logic             w_err;

  // Next-state and strobe decode; in_ready/out_valid depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_exec      = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_LD_A: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ld_a      = 1'b1;
          w_state_nxt = S_LD_B;
        end
      end
      S_LD_B: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ld_b      = 1'b1;
          w_state_nxt = S_LD_OP;
        end
      end
      S_LD_OP: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ld_op     = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = S_LD_A;
        end
      end
      default: w_state_nxt = S_LD_A;
    endcase
  end

  // State register; reset always returns to loading operand A.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand bank: loaded only on the matching handshake, otherwise held so
  // the ALU inputs stay stable through execute and output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_RESET;
    end else begin
      if (w_ld_a) begin
        r_alu_a <= bus.in_data;
      end
      if (w_ld_b) begin
        r_alu_b <= bus.in_data;
      end
      if (w_ld_op) begin
        r_alu_op <= bus.in_data[2:0];
      end
    end
  end

  // Flag derivation from the settled ALU result and held operands. An ADD
  // carried out exactly when the wrapped sum is smaller than operand A; a
  // SUB borrowed when A < B as unsigned values.
  always_comb begin
    w_cy = 1'b0;
    case (alu_op_e'(r_alu_op))
      OP_ADD:  w_cy = (alu_res < r_alu_a);
      OP_SUB:  w_cy = (r_alu_a < r_alu_b);
      default: w_cy = 1'b0;
    endcase
    w_err = ~is_valid_op(alu_op_e'(r_alu_op));
  end

  // Result bank: captured once in the execute cycle, held through output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_res <= '0;
      r_out_cy  <= 1'b0;
      r_out_err <= 1'b0;
    end else if (w_exec) begin
      r_out_res <= alu_res;
      r_out_cy  <= w_cy;
      r_out_err <= w_err;
    end
  end

  // Completed-operation counter, stepped on each accepted result; wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_cnt_inc) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_res   = r_out_res;
  assign bus.out_cy    = r_out_cy;
  assign bus.out_err   = r_out_err;

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: combinational ALU stand-in, a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic [7:0] op_count;

  alu_op_sequencer_if #(.W(8)) bus ();

  alu_op_sequencer #(.W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    case (alu_op)
      3'b001:  alu_res = alu_a + alu_b;
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a - alu_b;
      default: alu_res = 8'h00;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_phase = 0;
  logic [7:0] m_w [3];
  bit         m_busy = 0;
  bit         m_exec = 0;
  logic [7:0] m_res;
  bit         m_cy;
  bit         m_err;
  logic [8:0] m_sum;
  logic [7:0] m_cnt = 0;
  int         m_total = 0;
  bit         prev_rst = 0;

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_out_res", bus.out_res, 0);
      chk("rst_out_cy", bus.out_cy, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end
    if (reset) begin
      prev_rst = 1;
      m_phase  = 0;
      m_busy   = 0;
      m_exec   = 0;
      m_cnt    = 0;
      m_w[0]   = 0;
      m_w[1]   = 0;
      m_w[2]   = 0;
    end else begin
      prev_rst = 0;
      chk("in_ready", bus.in_ready, !m_busy);
      chk("out_valid", bus.out_valid, m_busy && !m_exec);
      chk("op_count", op_count, m_cnt);
      if (m_busy || m_phase >= 1) chk("hold_alu_a", alu_a, m_w[0]);
      if (m_busy || m_phase >= 2) chk("hold_alu_b", alu_b, m_w[1]);
      if (m_busy) chk("hold_alu_op", alu_op, m_w[2][2:0]);
      if (m_busy && !m_exec) begin
        chk("out_res", bus.out_res, m_res);
        chk("out_cy", bus.out_cy, m_cy);
        chk("out_err", bus.out_err, m_err);
      end
      // advance the model to what the coming edge does
      if (m_busy && m_exec) begin
        m_exec = 0;
      end else if (m_busy) begin
        if (bus.out_ready) begin
          m_busy = 0;
          m_cnt  = m_cnt + 8'd1;
          m_total++;
        end
      end else if (bus.in_valid) begin
        m_w[m_phase] = bus.in_data;
        m_phase++;
        if (m_phase == 3) begin
          m_phase = 0;
          m_busy  = 1;
          m_exec  = 1;
          m_err   = 0;
          m_cy    = 0;
          case (m_w[2][2:0])
            3'b001: begin
              m_sum = {1'b0, m_w[0]} + {1'b0, m_w[1]};
              m_res = m_sum[7:0];
              m_cy  = m_sum[8];
            end
            3'b010: m_res = m_w[0] & m_w[1];
            3'b011: m_res = m_w[0] | m_w[1];
            3'b100: begin
              m_res = m_w[0] - m_w[1];
              m_cy  = (m_w[0] < m_w[1]);
            end
            default: begin
              m_res = 8'h00;
              m_err = 1;
            end
          endcase
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // All drive tasks start and end just after a rising edge.
  task automatic send(input logic [7:0] d);
    int n;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic recv_lit(input logic [7:0] r, input logic cy, input logic err);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 50) begin
        errors++;
        $display("FAIL recv_timeout actual=out_valid_low required=out_valid_high");
        break;
      end
    end
    chk("lit_res", bus.out_res, r);
    chk("lit_cy", bus.out_cy, cy);
    chk("lit_err", bus.out_err, err);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] r, input logic cy, input logic err);
    send(a);
    send(b);
    send({5'b0, op});
    recv_lit(r, cy, err);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 50) begin
        errors++;
        $display("FAIL wait_valid_timeout actual=out_valid_low required=out_valid_high");
        break;
      end
    end
  endtask

  int base;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: ADD with latency check
    send(8'h05);
    send(8'h03);
    send(8'h01);
    @(negedge clk);
    chk("lat_exec_no_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid_2cyc", bus.out_valid, 1);
    recv_lit(8'h08, 1'b0, 1'b0);

    // 2: carry and borrow
    do_op(8'hF0, 8'h20, 3'b001, 8'h10, 1'b1, 1'b0);
    do_op(8'h03, 8'h05, 3'b100, 8'hFE, 1'b1, 1'b0);

    // 3: logic ops and invalid opcode
    do_op(8'hCC, 8'hAA, 3'b010, 8'h88, 1'b0, 1'b0);
    do_op(8'hCC, 8'hAA, 3'b011, 8'hEE, 1'b0, 1'b0);
    do_op(8'hCC, 8'hAA, 3'b111, 8'h00, 1'b0, 1'b1);

    // 4: backpressure hold
    send(8'h7F);
    send(8'h01);
    send(8'h01);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_res", bus.out_res, 8'h80);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("count_after_hold", op_count, 7);
    chk("valid_dropped", bus.out_valid, 0);
    @(posedge clk); #1;

    // 5a: reset after A loaded
    send(8'h11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstA_in_ready", bus.in_ready, 1);
    chk("rstA_alu_a", alu_a, 0);
    chk("rstA_count", op_count, 0);
    @(posedge clk); #1;
    do_op(8'h22, 8'h33, 3'b001, 8'h55, 1'b0, 1'b0);

    // 5b: reset while result is being offered
    send(8'h09);
    send(8'h04);
    send(8'h04);
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstO_out_valid", bus.out_valid, 0);
    chk("rstO_out_res", bus.out_res, 0);
    chk("rstO_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    do_op(8'hFF, 8'h01, 3'b001, 8'h00, 1'b1, 1'b0);

    // 6: random traffic with gaps and backpressure
    base = m_total;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            if (k == 2) send({5'b0, 3'($urandom_range(0, 7))});
            else        send(8'($urandom));
          end
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (m_total < base + 300 && cyc < 20000) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        bus.out_ready = 1'b0;
        if (m_total < base + 300) begin
          errors++;
          $display("FAIL random_timeout actual=%0d required=%0d", m_total - base, 300);
        end
      end
    join
    @(negedge clk);
    chk("final_count_wrapped", op_count, 8'd45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
